// File: rtl/xnor3_parity_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : xnor3_parity_sequencer
//  Description : Multi-cycle reduction-parity engine. One 3-input XNOR stage
//                folds two bits of the captured word per cycle into a 1-bit
//                accumulator, with valid/ready handshakes on both sides.
//                WIDTH must be even and at least 2; N = WIDTH/2 fold steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module xnor3_parity_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             VALID_IN,
    output logic             READY_IN,
    input  logic [WIDTH-1:0] DATA,
    input  logic             ODD_SEL,
    output logic             VALID_OUT,
    input  logic             READY_OUT,
    output logic             PARITY,
    output logic             BUSY,
    inout  wire              VDD,
    inout  wire              VSS
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_N     = WIDTH / 2;
    localparam int c_CNT_W = $clog2(c_N) + 1;

    // Counter value on the final fold step
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_N - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    // Every XNOR step adds one inversion; an odd step count leaves a net
    // inversion that the seed has to cancel.
    localparam logic               c_N_ODD = 1'(c_N % 2);

    // State encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_sr;
    logic               r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_mode;

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    logic w_fold;
    logic w_seed;

    // The single XNOR3 stage: accumulator combined with the two lowest bits
    assign w_fold = ~(r_acc ^ r_sr[0] ^ r_sr[1]);

    // Seed folds both the odd-step correction and the requested polarity
    assign w_seed = c_N_ODD ^ ODD_SEL;

    // Supply pins carry no logic; the latched mode is kept for debug only
    // since its effect is already applied through the seed.
    wire w_unused_ok = &{1'b0, VDD, VSS, r_mode};

    // ------------------------------------------------------------------------
    // Sequencer FSM and fold datapath; reset discards any in-flight word
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_acc   <= 1'b0;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (VALID_IN) begin
                        r_sr    <= DATA;
                        r_mode  <= ODD_SEL;
                        r_cnt   <= '0;
                        r_acc   <= w_seed;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_fold;
                    r_sr  <= r_sr >> 2;
                    r_cnt <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // acc is not touched here, so PARITY holds under backpressure
                    if (READY_OUT) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: pure decodes of registered state, no path from any input
    // ------------------------------------------------------------------------
    assign READY_IN  = (r_state == S_IDLE);
    assign VALID_OUT = (r_state == S_DONE);
    assign BUSY      = (r_state == S_RUN) || (r_state == S_DONE);
    assign PARITY    = r_acc;

endmodule
`default_nettype wire
